// File: rtl/sys_bridge_pkg.sv
// ---------------------------------------------------------------------------
// sys_bridge_pkg
// Shared definitions for the CPU data-bus bridge and its countdown timers:
//   - default address map (DM limit, timer 0/1 register window bases)
//   - timer CTRL bit positions and MODE codes
//   - timer register byte offsets inside a window
//   - timer FSM state encoding
//   - inTimerWindow(): helper that tests an address against a 12-byte window
// Configuration macro used by the bridge: SYS_BRIDGE_TIMER1_EN
// ---------------------------------------------------------------------------
package sys_bridge_pkg;

  // Default address map
  localparam logic [31:0] DEF_DM_LIMIT    = 32'h0000_2FFF;
  localparam logic [31:0] DEF_TIMER0_BASE = 32'h0000_7F00;
  localparam logic [31:0] DEF_TIMER1_BASE = 32'h0000_7F10;

  // Last byte offset inside a timer window (three 32-bit registers)
  localparam logic [31:0] TIMER_SPAN = 32'h0000_000B;

  // CTRL register layout: {IM, MODE[1:0], EN}
  localparam int CTRL_EN     = 0;
  localparam int CTRL_MODE   = 1;
  localparam int CTRL_MODE_W = 2;
  localparam int CTRL_IM     = 3;
  localparam int CTRL_W      = 4;

  // MODE codes; 2'b1x behaves like one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  // Register byte offsets within a timer window
  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_PRESET = 4'h4;
  localparam logic [3:0] OFF_COUNT  = 4'h8;

  // Timer FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } timer_state_e;

  // True when addr lies in [base, base + TIMER_SPAN]
  function automatic logic inTimerWindow(input logic [31:0] addr,
                                         input logic [31:0] base);
    return (addr >= base) && ((addr - base) <= TIMER_SPAN);
  endfunction

endpackage

// File: rtl/sys_bridge_timer.sv
// ---------------------------------------------------------------------------
// bridge_timer
// One programmable countdown timer: CTRL/PRESET/COUNT register file, the
// IDLE/LOAD/CNT/INT sequencing FSM and the interrupt request it produces.
// Ports:
//   clk        in   1   system clock, rising edge
//   reset      in   1   asynchronous, active-high
//   i_we       in   1   full-word write strobe for this window
//   i_off      in   4   byte offset of the access inside the window
//   i_wdata    in   32  write data
//   o_rdata    out  32  combinational read of the addressed register
//   o_irq      out  1   interrupt request (combinational from state/regs)
// ---------------------------------------------------------------------------
module bridge_timer
  import sys_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_we,
  input  logic [3:0]  i_off,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_irq
);

  timer_state_e        r_state;
  timer_state_e        w_stateNext;
  logic [CTRL_W-1:0]   r_ctrl;
  logic [CTRL_W-1:0]   w_ctrlNext;
  logic [31:0]         r_preset;
  logic [31:0]         w_presetNext;
  logic [31:0]         r_count;
  logic [31:0]         w_countNext;
  logic                r_pending;
  logic                w_pendingNext;
  logic                w_wrCtrl;
  logic                w_wrPreset;
  logic                w_reload;

  // COUNT is read-only, so only CTRL and PRESET can be written by the CPU.
  assign w_wrCtrl   = i_we && (i_off == OFF_CTRL);
  assign w_wrPreset = i_we && (i_off == OFF_PRESET);

  // Only 2'b01 reloads; every other MODE value runs as one-shot.
  assign w_reload = (r_ctrl[CTRL_MODE +: CTRL_MODE_W] == MODE_RELOAD);

  // Next-state logic. The FSM update is computed first and the CPU write is
  // applied afterwards so that a same-cycle CPU write overrides it. The FSM
  // only ever reacts to the registered CTRL, so a new CTRL value is seen
  // from the cycle after the write.
  always_comb begin
    w_stateNext   = r_state;
    w_ctrlNext    = r_ctrl;
    w_presetNext  = r_preset;
    w_countNext   = r_count;
    w_pendingNext = r_pending;

    case (r_state)
      IDLE: begin
        if (r_ctrl[CTRL_EN]) begin
          w_stateNext = LOAD;
        end
      end
      LOAD: begin
        w_countNext = r_preset;
        w_stateNext = CNT;
      end
      CNT: begin
        if (!r_ctrl[CTRL_EN]) begin
          w_stateNext = IDLE;
        end else if (r_count > 32'd1) begin
          w_countNext = r_count - 32'd1;
        end else begin
          w_countNext = 32'd0;
          w_stateNext = INT;
        end
      end
      INT: begin
        if (w_reload) begin
          w_stateNext = LOAD;
        end else begin
          // One-shot: disarm and keep the request latched until CTRL is
          // rewritten.
          w_ctrlNext[CTRL_EN] = 1'b0;
          w_pendingNext       = 1'b1;
          w_stateNext         = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase

    if (w_wrCtrl) begin
      w_ctrlNext    = i_wdata[CTRL_W-1:0];
      w_pendingNext = 1'b0;
    end
    if (w_wrPreset) begin
      w_presetNext = i_wdata;
    end
  end

  // State and register file update; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_ctrl    <= '0;
      r_preset  <= '0;
      r_count   <= '0;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_ctrl    <= w_ctrlNext;
      r_preset  <= w_presetNext;
      r_count   <= w_countNext;
      r_pending <= w_pendingNext;
    end
  end

  // The request is live for the single INT cycle (reload pulse) and stays
  // up afterwards while a one-shot completion is pending; IM masks both.
  assign o_irq = r_ctrl[CTRL_IM] && ((r_state == INT) || r_pending);

  // Register read mux; unused offsets read as zero.
  always_comb begin
    o_rdata = 32'h0;
    case (i_off)
      OFF_CTRL:   o_rdata = {{(32-CTRL_W){1'b0}}, r_ctrl};
      OFF_PRESET: o_rdata = r_preset;
      OFF_COUNT:  o_rdata = r_count;
      default:    o_rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/sys_bridge.sv
// ---------------------------------------------------------------------------
// sys_bridge
// Responder end of the CPU data-memory bus. Decodes each access to external
// data memory, timer 0 or (optionally) timer 1, returns read data with zero
// latency and packs the CPU hardware interrupt vector.
// Configuration macro: SYS_BRIDGE_TIMER1_EN
//   defined   -> timer 1 lives at TIMER1_BASE
//   undefined -> the timer 1 window reads 0, drops writes, HWInt[1] is 0
// Ports:
//   clk            in   1   system clock, rising edge
//   reset          in   1   asynchronous, active-high
//   m_data_addr    in   32  CPU byte address
//   m_data_wdata   in   32  CPU write data, lane-aligned
//   m_data_byteen  in   4   CPU byte-lane write enables (0 = read)
//   m_data_rdata   out  32  read data to the CPU (combinational)
//   dm_addr        out  32  address passthrough to DM
//   dm_wdata       out  32  write data passthrough to DM
//   dm_byteen      out  4   byte enables, only when DM is selected
//   dm_rdata       in   32  DM read data
//   irq_ext        in   1   external interrupt level
//   HWInt          out  6   {3'b0, irq_ext, timer1 irq, timer0 irq}
// ---------------------------------------------------------------------------
module sys_bridge
  import sys_bridge_pkg::*;
#(
  parameter logic [31:0] DM_LIMIT    = DEF_DM_LIMIT,
  parameter logic [31:0] TIMER0_BASE = DEF_TIMER0_BASE,
  parameter logic [31:0] TIMER1_BASE = DEF_TIMER1_BASE
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  output logic [31:0] m_data_rdata,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_byteen,
  input  logic [31:0] dm_rdata,
  input  logic        irq_ext,
  output logic [5:0]  HWInt
);

  logic        w_selDm;
  logic        w_inT0;
  logic        w_inT1;
  logic        w_fullWord;
  logic [3:0]  w_offT0;
  logic [31:0] w_rdataT0;
  logic [31:0] w_rdataT1;
  logic        w_irqT0;
  logic        w_irqT1;
  logic [1:0]  r_hwIrq;

  // Address decode. DM starts at 0 so only the upper limit matters.
  assign w_selDm    = (m_data_addr <= DM_LIMIT);
  assign w_inT0     = inTimerWindow(m_data_addr, TIMER0_BASE);
  assign w_inT1     = inTimerWindow(m_data_addr, TIMER1_BASE);
  assign w_fullWord = (m_data_byteen == 4'hF);

  // Windows are small, so only the low nibble is needed for the offset.
  assign w_offT0 = m_data_addr[3:0] - TIMER0_BASE[3:0];

  // DM sees address and data unconditionally; only the strobes are gated.
  assign dm_addr   = m_data_addr;
  assign dm_wdata  = m_data_wdata;
  assign dm_byteen = w_selDm ? m_data_byteen : 4'b0000;

  // Timers accept full-word writes only; partial writes are dropped.
  bridge_timer u_timer0 (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_inT0 && w_fullWord),
    .i_off   (w_offT0),
    .i_wdata (m_data_wdata),
    .o_rdata (w_rdataT0),
    .o_irq   (w_irqT0)
  );

`ifdef SYS_BRIDGE_TIMER1_EN
  logic [3:0] w_offT1;

  assign w_offT1 = m_data_addr[3:0] - TIMER1_BASE[3:0];

  bridge_timer u_timer1 (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_inT1 && w_fullWord),
    .i_off   (w_offT1),
    .i_wdata (m_data_wdata),
    .o_rdata (w_rdataT1),
    .o_irq   (w_irqT1)
  );
`else
  // Without timer 1 its window still decodes, but behaves as unmapped.
  assign w_rdataT1 = 32'h0;
  assign w_irqT1   = 1'b0;
`endif

  // Read-back mux toward the CPU; anything unmapped returns zero.
  always_comb begin
    m_data_rdata = 32'h0;
    if (w_selDm) begin
      m_data_rdata = dm_rdata;
    end else if (w_inT0) begin
      m_data_rdata = w_rdataT0;
    end else if (w_inT1) begin
      m_data_rdata = w_rdataT1;
    end
  end

  // Timer requests reach the CPU one cycle after the timer raises them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hwIrq <= 2'b00;
    end else begin
      r_hwIrq <= {w_irqT1, w_irqT0};
    end
  end

  assign HWInt = {3'b000, irq_ext, r_hwIrq};

endmodule

// File: tb/tb_sys_bridge.sv
// ---------------------------------------------------------------------------
// tb_sys_bridge
// Directed self-checking bench for sys_bridge: reset, DM routing, decode
// boundaries, partial timer writes, timer 1 window, one-shot and
// auto-reload timing, CPU/FSM write collisions and reset mid-count.
// ---------------------------------------------------------------------------
module tb_sys_bridge;

  localparam logic [31:0] T0      = 32'h0000_7F00;
  localparam logic [31:0] T1      = 32'h0000_7F10;
  localparam logic [31:0] IDLE_AD = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_data_rdata;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_byteen;
  logic [31:0] dm_rdata;
  logic        irq_ext;
  logic [5:0]  HWInt;

  int compareCount = 0;
  int errorCount   = 0;

  // Simple DM stand-in: read data is a fixed function of the address.
  assign dm_rdata = dm_addr ^ 32'h5A5A_0000;

  sys_bridge dut (
    .clk           (clk),
    .reset         (reset),
    .m_data_addr   (m_data_addr),
    .m_data_wdata  (m_data_wdata),
    .m_data_byteen (m_data_byteen),
    .m_data_rdata  (m_data_rdata),
    .dm_addr       (dm_addr),
    .dm_wdata      (dm_wdata),
    .dm_byteen     (dm_byteen),
    .dm_rdata      (dm_rdata),
    .irq_ext       (irq_ext),
    .HWInt         (HWInt)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // One bus write cycle: drive at a falling edge, commit on the rising edge.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] be);
    @(negedge clk);
    m_data_addr   = addr;
    m_data_wdata  = data;
    m_data_byteen = be;
    @(posedge clk);
    #1;
    m_data_addr   = IDLE_AD;
    m_data_wdata  = 32'h0;
    m_data_byteen = 4'h0;
  endtask

  // Combinational read sampled mid-cycle.
  task automatic readReg(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    m_data_addr   = addr;
    m_data_byteen = 4'h0;
    #1;
    data = m_data_rdata;
  endtask

  // Global time limit so the run can never hang.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] c;
    int          lat;
    int          nRise;
    int          riseAt [3];
    logic        prev;
    logic        seen;

    reset         = 1'b1;
    m_data_addr   = IDLE_AD;
    m_data_wdata  = 32'h0;
    m_data_byteen = 4'h0;
    irq_ext       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    readReg(T0, rd);
    checkOutput("rst_ctrl", rd, 32'h0);
    readReg(T0 + 32'h8, rd);
    checkOutput("rst_count", rd, 32'h0);
    checkOutput("rst_hwint", {26'h0, HWInt}, 32'h0);

    // External interrupt passes straight through to bit 2
    irq_ext = 1'b1;
    #1;
    checkOutput("irq_ext_on", {26'h0, HWInt}, 32'h0000_0004);
    irq_ext = 1'b0;
    #1;

    // DM routing of a word store
    @(negedge clk);
    m_data_addr   = 32'h0000_0100;
    m_data_wdata  = 32'hDEAD_BEEF;
    m_data_byteen = 4'hF;
    #1;
    checkOutput("dm_sw_byteen", {28'h0, dm_byteen}, 32'h0000_000F);
    checkOutput("dm_sw_addr", dm_addr, 32'h0000_0100);
    checkOutput("dm_sw_wdata", dm_wdata, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    m_data_byteen = 4'h0;
    readReg(32'h0000_0100, rd);
    checkOutput("dm_read", rd, 32'h5A5A_0100);

    // DM upper boundary and a byte store to an unmapped address
    @(negedge clk);
    m_data_addr   = 32'h0000_2FFF;
    m_data_byteen = 4'h8;
    #1;
    checkOutput("dm_limit_in", {28'h0, dm_byteen}, 32'h0000_0008);
    m_data_addr = 32'h0000_3000;
    #1;
    checkOutput("dm_limit_out", {28'h0, dm_byteen}, 32'h0);
    m_data_addr   = 32'h0000_7F30;
    m_data_wdata  = 32'h0000_00FF;
    m_data_byteen = 4'h1;
    #1;
    checkOutput("unmapped_sb_byteen", {28'h0, dm_byteen}, 32'h0);
    @(posedge clk);
    #1;
    m_data_byteen = 4'h0;
    readReg(32'h0000_7F30, rd);
    checkOutput("unmapped_read", rd, 32'h0);

    // Partial writes to timer registers are ignored
    applyStimulus(T0, 32'h0000_0001, 4'b0011);
    readReg(T0, rd);
    checkOutput("partial_ctrl", rd, 32'h0);
    applyStimulus(T0 + 32'h4, 32'h0000_0077, 4'b0001);
    readReg(T0 + 32'h4, rd);
    checkOutput("partial_preset", rd, 32'h0);

    // Timer 1 window
    applyStimulus(T1 + 32'h4, 32'h0000_0055, 4'hF);
    readReg(T1 + 32'h4, rd);
`ifdef SYS_BRIDGE_TIMER1_EN
    checkOutput("t1_preset", rd, 32'h0000_0055);
`else
    checkOutput("t1_preset", rd, 32'h0);
`endif
    checkOutput("t1_hwint1", {31'h0, HWInt[1]}, 32'h0);

    // One-shot: PRESET=5, CTRL=IM|EN. The request reaches HWInt on the
    // ninth falling edge after the CTRL write.
    applyStimulus(T0 + 32'h4, 32'd5, 4'hF);
    applyStimulus(T0, 32'h0000_0009, 4'hF);
    lat  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      if (HWInt[0]) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    checkOutput("os_latency", lat, 32'd9);
    repeat (5) @(negedge clk);
    checkOutput("os_hold", {31'h0, HWInt[0]}, 32'h1);
    readReg(T0, rd);
    checkOutput("os_ctrl_en_clr", rd, 32'h0000_0008);
    readReg(T0 + 32'h8, rd);
    checkOutput("os_count", rd, 32'h0);
    applyStimulus(T0, 32'h0, 4'hF);
    @(negedge clk);
    checkOutput("os_clr_reg_delay", {31'h0, HWInt[0]}, 32'h1);
    @(negedge clk);
    checkOutput("os_clr", {31'h0, HWInt[0]}, 32'h0);

    // PRESET=0: INT two cycles after LOAD, HWInt on the fifth falling edge
    applyStimulus(T0 + 32'h4, 32'd0, 4'hF);
    applyStimulus(T0, 32'h0000_0009, 4'hF);
    lat  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      if (HWInt[0]) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    checkOutput("p0_latency", lat, 32'd5);
    applyStimulus(T0, 32'h0, 4'hF);

    // Auto-reload: PRESET=3, CTRL=IM|RELOAD|EN -> one-cycle pulse every 5
    applyStimulus(T0 + 32'h4, 32'd3, 4'hF);
    applyStimulus(T0, 32'h0000_000B, 4'hF);
    m_data_addr   = T0 + 32'h8;
    m_data_byteen = 4'h0;
    nRise = 0;
    prev  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (HWInt[0] && !prev) begin
        if (nRise < 3) riseAt[nRise] = i;
        nRise++;
      end
      if (nRise == 1 && i == riseAt[0] + 1) begin
        checkOutput("ar_pulse_width", {31'h0, HWInt[0]}, 32'h0);
        checkOutput("ar_reload", m_data_rdata, 32'd3);
      end
      prev = HWInt[0];
    end
    checkOutput("ar_rises", (nRise >= 3) ? 32'd1 : 32'd0, 32'd1);
    if (nRise >= 3) begin
      checkOutput("ar_period1", riseAt[1] - riseAt[0], 32'd5);
      checkOutput("ar_period2", riseAt[2] - riseAt[1], 32'd5);
    end
    applyStimulus(T0, 32'h0, 4'hF);

    // Collisions while counting down from 100 without IM
    applyStimulus(T0 + 32'h4, 32'd100, 4'hF);
    applyStimulus(T0, 32'h0000_0001, 4'hF);
    repeat (10) @(negedge clk);
    // COUNT write on a decrement edge: ignored, decrement proceeds
    @(negedge clk);
    m_data_addr   = T0 + 32'h8;
    m_data_byteen = 4'h0;
    #1;
    c = m_data_rdata;
    m_data_wdata  = 32'h0000_1234;
    m_data_byteen = 4'hF;
    @(posedge clk);
    #1;
    m_data_byteen = 4'h0;
    readReg(T0 + 32'h8, rd);
    checkOutput("col_count_ro", rd, c - 32'd1);
    // CTRL=0 on a decrement edge: this edge still decrements, then frozen
    @(negedge clk);
    m_data_addr = T0 + 32'h8;
    #1;
    c = m_data_rdata;
    m_data_addr   = T0;
    m_data_wdata  = 32'h0;
    m_data_byteen = 4'hF;
    @(posedge clk);
    #1;
    m_data_byteen = 4'h0;
    readReg(T0 + 32'h8, rd);
    checkOutput("col_ctrl_edge", rd, c - 32'd1);
    repeat (5) @(negedge clk);
    readReg(T0 + 32'h8, rd);
    checkOutput("col_frozen", rd, c - 32'd1);
    readReg(T0, rd);
    checkOutput("col_ctrl", rd, 32'h0);

    // Reset mid-count at COUNT=40
    applyStimulus(T0 + 32'h4, 32'd100, 4'hF);
    applyStimulus(T0, 32'h0000_0009, 4'hF);
    m_data_addr   = T0 + 32'h8;
    m_data_byteen = 4'h0;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (m_data_rdata == 32'd40) seen = 1'b1;
    end
    checkOutput("mid_reach40", {31'h0, seen}, 32'h1);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_count", m_data_rdata, 32'h0);
    m_data_addr = T0;
    #1;
    checkOutput("mid_rst_ctrl", m_data_rdata, 32'h0);
    checkOutput("mid_rst_hwint", {26'h0, HWInt}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    readReg(T0 + 32'h8, rd);
    checkOutput("post_rst_count", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, errorCount);
    $finish;
  end

endmodule
